// File: rtl/mac_result_drain.sv
// mac_result_drain: waits for a MAC-chain pass to finish, snapshots every
// accumulator into a local bank, streams the words out over valid/ready, then
// pulses a one-cycle clear back to the chain.
// Optional build macro: RESULT_SAT_EN (16-bit saturated result words).
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start
// ARM     | armed, waiting for the chain enable to rise
// RUN     | pass in progress, waiting for the chain enable to fall
// SETTLE  | enable low, counting down before the snapshot
// CAPTURE | all accumulators copied into the bank this cycle
// DRAIN   | presenting bank[idx] until the last word is accepted
// CLEAR   | clr and done high for one cycle
module mac_result_drain #(
    parameter int NUM_MAC    = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SETTLE_CYC = 2,
`ifdef RESULT_SAT_EN
    localparam int OUT_W     = 16,
`else
    localparam int OUT_W     = ACC_WIDTH,
`endif
    localparam int IDX_W     = $clog2(NUM_MAC)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         en_in,
    input  logic [NUM_MAC*ACC_WIDTH-1:0] couts_flat,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [OUT_W-1:0]             out_data,
    output logic [IDX_W-1:0]             out_idx,
    output logic                         out_last,
    output logic                         clr,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [2:0] {
        IDLE, ARM, RUN, SETTLE, CAPTURE, DRAIN, CLEAR
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MAC - 1);

    state_t           state;
    logic [3:0]       settle_cnt;
    logic [OUT_W-1:0] bank [NUM_MAC];
    logic [IDX_W-1:0] nxt_idx;

    // Converts one accumulator to a result word; saturation happens here so
    // the bank only ever holds final output values.
    function automatic logic [OUT_W-1:0] fit(input logic [ACC_WIDTH-1:0] acc);
`ifdef RESULT_SAT_EN
        fit = (|acc[ACC_WIDTH-1:16]) ? 16'hFFFF : acc[15:0];
`else
        fit = acc;
`endif
    endfunction

    assign nxt_idx = out_idx + IDX_W'(1);

    // Sequencer, snapshot bank and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            clr        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < NUM_MAC; i++) begin
                bank[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (en_in) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en_in) begin
                        if (SETTLE_CYC == 0) begin
                            state <= CAPTURE;
                        end else begin
                            state      <= SETTLE;
                            settle_cnt <= 4'(SETTLE_CYC);
                        end
                    end
                end
                SETTLE: begin
                    // A re-asserted enable means the chain is still running.
                    if (en_in) begin
                        state <= RUN;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                        if (settle_cnt <= 4'd1) begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    // Word 0 is loaded straight from the input so it is
                    // presented on the first DRAIN cycle.
                    for (int i = 0; i < NUM_MAC; i++) begin
                        bank[i] <= fit(couts_flat[i*ACC_WIDTH +: ACC_WIDTH]);
                    end
                    out_data  <= fit(couts_flat[ACC_WIDTH-1:0]);
                    out_idx   <= '0;
                    out_last  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_idx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_idx   <= '0;
                            clr       <= 1'b1;
                            done      <= 1'b1;
                            state     <= CLEAR;
                        end else begin
                            out_idx  <= nxt_idx;
                            out_data <= bank[nxt_idx];
                            out_last <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                CLEAR: begin
                    clr   <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain (NUM_MAC=8, ACC_WIDTH=24, SETTLE_CYC=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mac_result_drain;

`ifdef RESULT_SAT_EN
    localparam int OUT_W = 16;
`else
    localparam int OUT_W = 24;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               en_in = 1'b0;
    logic [8*24-1:0]    couts_flat = '0;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic [OUT_W-1:0]   out_data;
    logic [2:0]         out_idx;
    logic               out_last;
    logic               clr;
    logic               busy;
    logic               done;

    int vectors = 0;
    int miscompares = 0;
    int clr_cnt = 0;
    int done_cnt = 0;
    int cyc;
    int n;
    int clr_before;
    logic [31:0] exp_words [8];

    mac_result_drain #(.NUM_MAC(8), .ACC_WIDTH(24), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .en_in(en_in),
        .couts_flat(couts_flat), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .clr(clr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clr) clr_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_linear();
        for (int i = 0; i < 8; i++) begin
            couts_flat[i*24 +: 24] = 24'(i*100 + 5);
            exp_words[i] = 32'(i*100 + 5);
        end
    endtask

    // start, enable high for 10 cycles, enable low; checks busy and the
    // 3-cycle settle+capture latency before the first word appears.
    task automatic run_pass_to_drain();
        start = 1'b1;
        step();
        chk("busy_rise", 32'(busy), 32'd1);
        start = 1'b0;
        en_in = 1'b1;
        repeat (10) step();
        en_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("capture_latency", 32'(out_valid), 32'(k == 4));
        end
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
    task automatic drain(input int mode, input int change_at, input int start_at,
                         output int cycles);
        int got = 0;
        int c = 0;
        bit holding = 0;
        bit pulsed = 0;
        logic [31:0] held_d = '0;
        logic [31:0] held_i = '0;
        while (got < 8 && c < 200) begin
            out_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            start = (start_at >= 0 && got == start_at && !pulsed);
            if (start) pulsed = 1;
            if (change_at >= 0 && got == change_at) couts_flat = '1;
            if (out_valid) begin
                if (holding) begin
                    chk("hold_data", 32'(out_data), held_d);
                    chk("hold_idx", 32'(out_idx), held_i);
                end
                if (out_ready) begin
                    chk("data", 32'(out_data), exp_words[got]);
                    chk("idx", 32'(out_idx), 32'(got));
                    chk("last", 32'(out_last), 32'(got == 7));
                    chk("busy_drain", 32'(busy), 32'd1);
                    got++;
                    holding = 0;
                end else begin
                    held_d = 32'(out_data);
                    held_i = 32'(out_idx);
                    holding = 1;
                end
            end
            step();
            start = 1'b0;
            c++;
        end
        chk("handshakes", 32'(got), 32'd8);
        cycles = c;
    endtask

    task automatic post_clear();
        chk("clr_pulse", 32'(clr), 32'd1);
        chk("done_pulse", 32'(done), 32'd1);
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("busy_clear", 32'(busy), 32'd1);
        step();
        chk("clr_end", 32'(clr), 32'd0);
        chk("done_end", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        step();
        chk("busy_stay_idle", 32'(busy), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clr", 32'(clr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        step();

        // Full pass, ready always high: 8 words on 8 consecutive cycles
        set_linear();
        run_pass_to_drain();
        drain(0, -1, -1, cyc);
        chk("b2b_cycles", 32'(cyc), 32'd8);
        post_clear();
        chk("done_count1", 32'(done_cnt), 32'd1);
        chk("clr_count1", 32'(clr_cnt), 32'd1);

        // Ready toggling 1,0,0: data held while stalled, no drop/duplicate
        run_pass_to_drain();
        drain(1, -1, -1, cyc);
        chk("stall_cycles", 32'(cyc), 32'd22);
        post_clear();
        chk("done_count2", 32'(done_cnt), 32'd2);

        // couts change during drain does not reach out_data
        run_pass_to_drain();
        drain(0, 2, -1, cyc);
        post_clear();
        set_linear();

        // Reset in DRAIN at idx 3: no clr, fresh pass afterwards
        run_pass_to_drain();
        clr_before = clr_cnt;
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_idx == 3'd3) && n < 20) begin
            step();
            n++;
        end
        chk("reach_idx3", 32'(out_idx), 32'd3);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_idx", 32'(out_idx), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("mid_rst_no_clr", 32'(clr_cnt), 32'(clr_before));
        chk("mid_rst_idle", 32'(busy), 32'd0);
        run_pass_to_drain();
        drain(0, -1, -1, cyc);
        post_clear();

        // Enable re-asserts in first SETTLE cycle; start during DRAIN ignored
        n = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        en_in = 1'b1;
        repeat (10) step();
        en_in = 1'b0;
        step();
        chk("settle_valid0", 32'(out_valid), 32'd0);
        en_in = 1'b1;
        repeat (4) begin
            step();
            chk("resettle_no_cap", 32'(out_valid), 32'd0);
        end
        en_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("resettle_latency", 32'(out_valid), 32'(k == 4));
        end
        drain(0, -1, 3, cyc);
        post_clear();
        chk("single_done", 32'(done_cnt - n), 32'd1);
        step();
        chk("start_ignored_idle", 32'(busy), 32'd0);

        // Result word conversion on large accumulator values
        couts_flat[0*24 +: 24] = 24'h012345;
        couts_flat[1*24 +: 24] = 24'h00FFFF;
        couts_flat[2*24 +: 24] = 24'h000010;
        couts_flat[3*24 +: 24] = 24'h010000;
        couts_flat[4*24 +: 24] = 24'hFFFFFF;
        couts_flat[5*24 +: 24] = 24'h00ABCD;
        couts_flat[6*24 +: 24] = 24'h000000;
        couts_flat[7*24 +: 24] = 24'h00FFFE;
`ifdef RESULT_SAT_EN
        exp_words[0] = 32'hFFFF; exp_words[1] = 32'hFFFF;
        exp_words[2] = 32'h0010; exp_words[3] = 32'hFFFF;
        exp_words[4] = 32'hFFFF; exp_words[5] = 32'hABCD;
        exp_words[6] = 32'h0000; exp_words[7] = 32'hFFFE;
`else
        exp_words[0] = 32'h012345; exp_words[1] = 32'h00FFFF;
        exp_words[2] = 32'h000010; exp_words[3] = 32'h010000;
        exp_words[4] = 32'hFFFFFF; exp_words[5] = 32'h00ABCD;
        exp_words[6] = 32'h000000; exp_words[7] = 32'h00FFFE;
`endif
        run_pass_to_drain();
        drain(0, -1, -1, cyc);
        post_clear();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
